mul_issue_unit: RTL

Reservation station and result collector for the pipelined multiply functional unit. Holds up to DEPTH dispatched multiply micro-ops and captures pending operands from the common data bus (CDB). Issues one operand pair at a time to the multiplier with a one-cycle valid pulse, then hands the multiplier's held result to the CDB arbiter and returns the read strobe that frees the multiplier. A flush discards all queued entries and drops any result still in flight.

---
 rtl/mul_issue_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/mul_issue_unit.sv
// mul_issue_unit: multiply reservation station with CDB snoop, single-outstanding issue and result collection
module mul_issue_unit #(
  parameter int ROB_IX = 2,
  parameter int DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush_in,
  input  logic              disp_valid_in,
  output logic              disp_ready_out,
  input  logic [ROB_IX:0]   disp_rob_ix_in,
  input  logic              disp_q1_pend_in,
  input  logic              disp_q2_pend_in,
  input  logic [ROB_IX:0]   disp_q1_in,
  input  logic [ROB_IX:0]   disp_q2_in,
  input  logic [31:0]       disp_v1_in,
  input  logic [31:0]       disp_v2_in,
  input  logic              cdb_valid_in,
  input  logic [ROB_IX:0]   cdb_rob_ix_in,
  input  logic [31:0]       cdb_data_in,
  input  logic              mul_ready_in,
  output logic              mul_valid_out,
  output logic [31:0]       mul_rval1_out,
  output logic [31:0]       mul_rval2_out,
  output logic [ROB_IX:0]   mul_rob_ix_out,
  input  logic              mul_valid_in,
  input  logic [31:0]       mul_data_in,
  input  logic [ROB_IX:0]   mul_rob_ix_in,
  output logic              mul_read_out,
  output logic              res_valid_out,
  output logic [ROB_IX:0]   res_rob_ix_out,
  output logic [31:0]       res_data_out,
  input  logic              res_grant_in
);
  localparam int SW = $clog2(DEPTH);
  logic [DEPTH-1:0] busy, p1, p2, rdy;
  logic [ROB_IX:0] rob [DEPTH];
  logic [ROB_IX:0] t1 [DEPTH];
  logic [ROB_IX:0] t2 [DEPTH];
  logic [31:0] v1 [DEPTH];
  logic [31:0] v2 [DEPTH];
  logic [SW-1:0] fi, si;
  logic in_flight, drop, disp, b1, b2;
  // lowest free entry for dispatch and lowest operand-ready entry for issue
  always_comb begin
    rdy = busy & ~p1 & ~p2;
    fi = '0;
    si = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) fi = SW'(i);
      if (rdy[i]) si = SW'(i);
    end
  end
  assign disp_ready_out = ~&busy;
  assign disp = disp_valid_in && disp_ready_out && !flush_in;
  assign b1 = cdb_valid_in && disp_q1_pend_in && cdb_rob_ix_in == disp_q1_in;
  assign b2 = cdb_valid_in && disp_q2_pend_in && cdb_rob_ix_in == disp_q2_in;
  assign mul_valid_out = !flush_in && !in_flight && mul_ready_in && |rdy;
  assign mul_rval1_out = v1[si];
  assign mul_rval2_out = v2[si];
  assign mul_rob_ix_out = rob[si];
  assign res_valid_out = mul_valid_in && !drop && !flush_in;
  assign res_rob_ix_out = mul_rob_ix_in;
  assign res_data_out = mul_data_in;
  assign mul_read_out = mul_valid_in && ((res_valid_out && res_grant_in) || drop || flush_in);
  // entry update: snoop, then free on issue, then allocate on dispatch; flush overrides busy
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy <= '0;
      p1 <= '0;
      p2 <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rob[i] <= '0;
        t1[i] <= '0;
        t2[i] <= '0;
        v1[i] <= '0;
        v2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && p1[i] && cdb_valid_in && cdb_rob_ix_in == t1[i]) begin
          p1[i] <= 1'b0;
          v1[i] <= cdb_data_in;
        end
        if (busy[i] && p2[i] && cdb_valid_in && cdb_rob_ix_in == t2[i]) begin
          p2[i] <= 1'b0;
          v2[i] <= cdb_data_in;
        end
        if (mul_valid_out && si == SW'(i)) busy[i] <= 1'b0;
        if (disp && fi == SW'(i)) begin
          busy[i] <= 1'b1;
          rob[i] <= disp_rob_ix_in;
          p1[i] <= disp_q1_pend_in && !b1;
          p2[i] <= disp_q2_pend_in && !b2;
          t1[i] <= disp_q1_in;
          t2[i] <= disp_q2_in;
          v1[i] <= b1 ? cdb_data_in : disp_v1_in;
          v2[i] <= b2 ? cdb_data_in : disp_v2_in;
        end
        if (flush_in) busy[i] <= 1'b0;
      end
    end
  end
  // one multiply outstanding; drop marks a squashed result not yet returned
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      in_flight <= 1'b0;
      drop <= 1'b0;
    end else begin
      in_flight <= mul_valid_out || (in_flight && !mul_read_out);
      drop <= !mul_read_out && (drop || (flush_in && in_flight && !mul_valid_in));
    end
  end
endmodule
